spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receive end of the neuron datapath. Converts a single-bit spike train, such as the output neuron's spike line, into a multi-bit firing-rate word.
- Counts rising edges of the spike line over a fixed window of clock cycles.
- Presents each window's count on a valid/ready output port, with a sticky overrun flag.
- Lets the neuron core be closed-loop tested and its output read back as a number, the reverse of feeding 4-bit operands in.

Parameters:
- WINDOW_LEN, default 16: window length in clock cycles; must be >= 2.
- CNT_W, default 5: width of the rate count; the count saturates at 2^CNT_W-1.
- SYNC_STAGES, default 2: synchroniser depth on spike_in; must be >= 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- en  in  1  decoder enable; level-sensitive.
- spike_in  in  1  raw spike line; may be asynchronous to clk.
- rate_ready  in  1  consumer accepts rate_out.
- clr_ovr  in  1  single-cycle pulse; clears overrun.
- rate_out  out  CNT_W  spike count of the last completed window.
- rate_valid  out  1  rate_out holds an unconsumed result.
- overrun  out  1  sticky; a completed window was dropped.
- busy  out  1  high while state is ACCUM.

Behaviour:
- Clocking and reset (already decided): one clock, clk. rst_n is asynchronous, active-low.
- Reset values: rate_out=0, rate_valid=0, overrun=0, busy=0. All sync flops and counters are cleared and state=IDLE.
- Spike front end:
  - spike_in passes through SYNC_STAGES flops, then a rising-edge detector giving a one-cycle edge pulse.
  - Latency from spike_in to edge pulse is SYNC_STAGES+1 cycles.
  - Only 0->1 transitions count; a held-high level counts once.
- State machine, 2 states:
  - IDLE: busy=0, counters held at 0. If en=1 at an edge: go to ACCUM with win_cnt=0 and spk_cnt=0.
  - ACCUM: busy=1. Each edge: win_cnt+1, and spk_cnt+1 if the edge pulse is high (saturating at 2^CNT_W-1).
  - End of window: at the edge where win_cnt==WINDOW_LEN-1, the closing count is spk_cnt plus the current pulse, saturated. Call this the result.
  - At the same edge, win_cnt and spk_cnt reset to 0, and the next window starts with no idle gap.
  - First result appears WINDOW_LEN edges after entering ACCUM.
  - If en=0 at any edge in ACCUM: go to IDLE and discard the partial count. rate_out, rate_valid and overrun are unaffected.
  - If en=0 on the window-closing edge: that window still completes and delivers, then the state goes to IDLE.
- Output handshake (at a window-closing edge):
  - rate_valid=0: rate_out<=result, rate_valid<=1.
  - rate_valid=1 and rate_ready=1: the old value is accepted and replaced in the same edge. rate_out<=result, rate_valid stays 1, no overrun.
  - rate_valid=1 and rate_ready=0: result is dropped, rate_out holds, overrun<=1.
- Handshake, no window closing: rate_valid=1 and rate_ready=1 gives rate_valid<=0; rate_out holds its value.
- rate_out is stable while rate_valid=1 and rate_ready=0.
- overrun: cleared by clr_ovr. If set and clear fall in the same edge, set wins.
- Widths: win_cnt is $clog2(WINDOW_LEN) bits and wraps only via the explicit end-of-window reset. No implicit truncation of spk_cnt.

Decomposition:
- Package neuron_pkg:
  - state enum {IDLE, ACCUM}.
  - Default constants DEF_WINDOW_LEN=16, DEF_CNT_W=5.
  - Localparam function for win_cnt width.
- One sub-module, spike_edge_sync: SYNC_STAGES-deep synchroniser plus rising-edge detector. Ports clk, rst_n, d_in, edge_out.

Test Plan:
- Idle count: spike_in=0, en=1, rate_ready=0 from reset -> rate_valid rises exactly 16 edges after ACCUM entry, rate_out=0, busy=1.
- Rate measure: spike_in toggles every clk (8 rising edges per 16 cycles), rate_ready=1 -> from the second window onward each result is rate_out=8, one per 16 cycles.
- Saturation: CNT_W=3, spike_in toggling every clk -> rate_out=7 (not 0) every window.
- Back-pressure and overrun: rate_ready=0 through two windows of 3 spikes then 5 spikes.
  - After window 2: rate_out=3 holds and overrun=1.
  - rate_ready=1 for one cycle -> rate_valid=0 next cycle.
  - clr_ovr pulse -> overrun=0.
- Simultaneous accept and close: rate_ready=1 on a window-closing edge with rate_valid=1 -> rate_valid stays 1, new count loaded, overrun stays 0.
- Abort and reset: en=0 at win_cnt=9 after 4 spikes -> IDLE, busy=0, no result.
  - Re-enable -> a fresh full 16-cycle window.
  - rst_n low mid-window, asynchronously -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron datapath receive side.
package neuron_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int DEF_WINDOW_LEN  = 16;
  localparam int DEF_CNT_W       = 5;
  localparam int DEF_SYNC_STAGES = 2;

  // Window counter width; never narrower than one bit.
  function automatic int win_cnt_w(input int window_len);
    return (window_len < 2) ? 1 : $clog2(window_len);
  endfunction

endpackage

// File: rtl/spike_edge_sync.sv
// Multi-flop synchroniser for an asynchronous spike line followed by a
// registered rising-edge detector (one-cycle pulse per 0->1 transition).
module spike_edge_sync
  import neuron_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_r;

  // Synchroniser chain, previous-level flop and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_in};
      prev_r <= sync_r[SYNC_STAGES-1];
      edge_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
    end
  end

  assign edge_out = edge_r;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges over a fixed window of clock cycles and offers
// each window's count on a valid/ready port with a sticky overrun flag.
module spike_rate_decoder
  import neuron_pkg::*;
#(
  parameter int WINDOW_LEN  = DEF_WINDOW_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic             rate_ready,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int               WIN_W    = win_cnt_w(WINDOW_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [WIN_W-1:0] win_cnt_r;
  logic [WIN_W-1:0] win_nxt_s;
  logic [CNT_W-1:0] spk_cnt_r;
  logic [CNT_W-1:0] spk_nxt_s;
  logic [CNT_W:0]   spk_sum_s;
  logic [CNT_W-1:0] result_s;
  logic             close_s;
  logic             edge_s;

  logic [CNT_W-1:0] rate_out_r;
  logic [CNT_W-1:0] rate_nxt_s;
  logic             rate_valid_r;
  logic             valid_nxt_s;
  logic             overrun_r;
  logic             ovr_nxt_s;
  logic             busy_r;

  spike_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (spike_in),
    .edge_out(edge_s)
  );

  // Spike count including the current pulse, saturated to the count width.
  always_comb begin
    spk_sum_s = {1'b0, spk_cnt_r} + {{CNT_W{1'b0}}, edge_s};
    if (spk_sum_s[CNT_W]) begin
      result_s = CNT_MAX;
    end else begin
      result_s = spk_sum_s[CNT_W-1:0];
    end
  end

  // Window FSM; the closing edge delivers even when en has dropped.
  always_comb begin
    state_nxt_s = state_r;
    win_nxt_s   = win_cnt_r;
    spk_nxt_s   = spk_cnt_r;
    close_s     = 1'b0;
    case (state_r)
      IDLE: begin
        win_nxt_s = {WIN_W{1'b0}};
        spk_nxt_s = {CNT_W{1'b0}};
        if (en) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCUM: begin
        if (win_cnt_r == WIN_LAST) begin
          close_s     = 1'b1;
          win_nxt_s   = {WIN_W{1'b0}};
          spk_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = en ? ACCUM : IDLE;
        end else if (!en) begin
          win_nxt_s   = {WIN_W{1'b0}};
          spk_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = IDLE;
        end else begin
          win_nxt_s   = win_cnt_r + WIN_W'(1);
          spk_nxt_s   = result_s;
          state_nxt_s = ACCUM;
        end
      end
      default: begin
        win_nxt_s   = {WIN_W{1'b0}};
        spk_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output handshake: a closing window replaces an accepted or empty slot,
  // otherwise it is dropped and flagged. Setting overrun beats clearing it.
  always_comb begin
    rate_nxt_s  = rate_out_r;
    valid_nxt_s = rate_valid_r;
    if (clr_ovr) begin
      ovr_nxt_s = 1'b0;
    end else begin
      ovr_nxt_s = overrun_r;
    end
    if (close_s) begin
      if (!rate_valid_r || rate_ready) begin
        rate_nxt_s  = result_s;
        valid_nxt_s = 1'b1;
      end else begin
        ovr_nxt_s = 1'b1;
      end
    end else if (rate_valid_r && rate_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = rate_valid_r;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      win_cnt_r <= {WIN_W{1'b0}};
      spk_cnt_r <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      win_cnt_r <= win_nxt_s;
      spk_cnt_r <= spk_nxt_s;
      busy_r    <= (state_nxt_s == ACCUM);
    end
  end

  // Output port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out_r   <= {CNT_W{1'b0}};
      rate_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      rate_out_r   <= rate_nxt_s;
      rate_valid_r <= valid_nxt_s;
      overrun_r    <= ovr_nxt_s;
    end
  end

  assign rate_out   = rate_out_r;
  assign rate_valid = rate_valid_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: default instance plus a
// CNT_W=3 instance for saturation, scoreboard queues for delivered results.
module tb_spike_rate_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       spike_in;
  logic       rate_ready;
  logic       clr_ovr;
  logic [4:0] rate_out;
  logic       rate_valid;
  logic       overrun;
  logic       busy;

  logic       en_sat;
  logic       ready_sat;
  logic [2:0] rate_out_sat;
  logic       valid_sat;
  logic       ovr_sat;
  logic       busy_sat;

  logic       spike_mode;
  logic       spike_lvl;
  logic       chk_period;

  int          err_cnt  = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          last_pop = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_sat_q[$];

  spike_rate_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .spike_in  (spike_in),
    .rate_ready(rate_ready),
    .clr_ovr   (clr_ovr),
    .rate_out  (rate_out),
    .rate_valid(rate_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(3), .SYNC_STAGES(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_sat),
    .spike_in  (spike_in),
    .rate_ready(ready_sat),
    .clr_ovr   (clr_ovr),
    .rate_out  (rate_out_sat),
    .rate_valid(valid_sat),
    .overrun   (ovr_sat),
    .busy      (busy_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Spike line driver: toggles every cycle or follows spike_lvl.
  initial begin
    spike_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (spike_mode) spike_in = ~spike_in;
      else spike_in = spike_lvl;
    end
  end

  // Scoreboard for the default instance: one pop per accepted transfer.
  always @(negedge clk) begin
    if (rst_n && rate_valid && rate_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_pop", 32'(exp_q.size()), 32'd1);
      end else begin
        check_eq("rate_sb", 32'(rate_out), exp_q.pop_front());
        if (chk_period) begin
          if (last_pop > 0) check_eq("rate_period", 32'(cyc - last_pop), 32'd16);
          last_pop = cyc;
        end
      end
    end
  end

  // Scoreboard for the saturation instance.
  always @(negedge clk) begin
    if (rst_n && valid_sat && ready_sat) begin
      if (exp_sat_q.size() == 0) begin
        check_eq("sat_sb_pop", 32'(exp_sat_q.size()), 32'd1);
      end else begin
        check_eq("sat_sb", 32'(rate_out_sat), exp_sat_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n      = 1'b0;
    en         = 1'b0;
    en_sat     = 1'b0;
    rate_ready = 1'b0;
    clr_ovr    = 1'b0;
    spike_mode = 1'b0;
    spike_lvl  = 1'b0;
    chk_period = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic spike_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      spike_lvl = 1'b1;
      tick();
      spike_lvl = 1'b0;
    end
  endtask

  initial begin
    ready_sat = 1'b1;
    reset_dut();
    @(negedge clk);
    check_eq("rst_rate", 32'(rate_out), 32'd0);
    check_eq("rst_valid", 32'(rate_valid), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Idle count: first result exactly 16 edges after ACCUM entry.
    tick();
    en = 1'b1;
    repeat (16) tick();
    @(negedge clk);
    check_eq("idle_valid_e15", 32'(rate_valid), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check_eq("idle_valid_e16", 32'(rate_valid), 32'd1);
    check_eq("idle_rate", 32'(rate_out), 32'd0);
    check_eq("idle_busy_e16", 32'(busy), 32'd1);

    // Rate measure and saturation: continuous toggling, 8 rising edges/window.
    reset_dut();
    spike_mode = 1'b1;
    rate_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'd8);
      exp_sat_q.push_back(32'd7);
    end
    chk_period = 1'b1;
    last_pop   = 0;
    en         = 1'b1;
    en_sat     = 1'b1;
    repeat (30) tick();
    @(negedge clk);
    check_eq("sat_busy", 32'(busy_sat), 32'd1);
    repeat (35) tick();
    en     = 1'b0;
    en_sat = 1'b0;
    repeat (3) tick();
    chk_period = 1'b0;
    spike_mode = 1'b0;
    rate_ready = 1'b0;
    check_eq("rate_q_drain", 32'(exp_q.size()), 32'd0);
    check_eq("sat_q_drain", 32'(exp_sat_q.size()), 32'd0);
    check_eq("sat_ovr", 32'(ovr_sat), 32'd0);

    // Back-pressure: 3 spikes then 5 spikes with rate_ready low.
    reset_dut();
    en = 1'b1;
    spike_pulses(3);
    repeat (11) tick();
    spike_pulses(5);
    repeat (6) tick();
    @(negedge clk);
    check_eq("bp_rate_hold", 32'(rate_out), 32'd3);
    check_eq("bp_valid", 32'(rate_valid), 32'd1);
    check_eq("bp_ovr_set", 32'(overrun), 32'd1);
    tick();
    exp_q.push_back(32'd3);
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_valid_drop", 32'(rate_valid), 32'd0);
    check_eq("bp_ovr_sticky", 32'(overrun), 32'd1);
    tick();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    @(negedge clk);
    check_eq("bp_ovr_clr", 32'(overrun), 32'd0);
    en = 1'b0;
    tick();

    // Simultaneous accept and close at the window-closing edge.
    reset_dut();
    en = 1'b1;
    repeat (17) tick();
    @(negedge clk);
    check_eq("sim_w1_valid", 32'(rate_valid), 32'd1);
    check_eq("sim_w1_rate", 32'(rate_out), 32'd0);
    spike_pulses(2);
    repeat (11) tick();
    exp_q.push_back(32'd0);
    rate_ready = 1'b1;
    tick();
    rate_ready = 1'b0;
    @(negedge clk);
    check_eq("sim_valid", 32'(rate_valid), 32'd1);
    check_eq("sim_rate", 32'(rate_out), 32'd2);
    check_eq("sim_ovr", 32'(overrun), 32'd0);
    tick();
    exp_q.push_back(32'd2);
    rate_ready = 1'b1;
    en         = 1'b0;
    tick();
    rate_ready = 1'b0;
    @(negedge clk);
    check_eq("sim_drained", 32'(rate_valid), 32'd0);

    // Abort at win_cnt=9 after 4 spikes, then a fresh full window.
    reset_dut();
    en = 1'b1;
    spike_pulses(4);
    repeat (2) tick();
    en = 1'b0;
    tick();
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_valid", 32'(rate_valid), 32'd0);
    repeat (10) tick();
    @(negedge clk);
    check_eq("abort_no_result", 32'(rate_valid), 32'd0);
    en = 1'b1;
    spike_pulses(1);
    repeat (14) tick();
    @(negedge clk);
    check_eq("fresh_valid_e15", 32'(rate_valid), 32'd0);
    tick();
    @(negedge clk);
    check_eq("fresh_valid_e16", 32'(rate_valid), 32'd1);
    check_eq("fresh_rate", 32'(rate_out), 32'd1);
    check_eq("fresh_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-window, sampled before any clock edge.
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rate", 32'(rate_out), 32'd0);
    check_eq("arst_valid", 32'(rate_valid), 32'd0);
    check_eq("arst_ovr", 32'(overrun), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    check_eq("final_q", 32'(exp_q.size()), 32'd0);
    check_eq("final_sat_q", 32'(exp_sat_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
